// File: rtl/crc32_bit_feeder.sv
// Byte-to-bit front end for a serial MSB-first CRC-32 stage: serialises framed bytes
// gap-free, resets the CRC stage before each frame and captures its result afterwards.
module crc32_bit_feeder (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic        bit_out,
   output logic        crc_rst,
   input  logic [31:0] crc_in,
   output logic [31:0] frame_crc,
   output logic        crc_valid,
   output logic        underrun,
   output logic [2:0]  dbg_state_o
);

   // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both
   // high; in_last is only meaningful alongside in_valid.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      SHIFT   = 3'd2,
      CAP1    = 3'd3,
      CAP2    = 3'd4,
      DISCARD = 3'd5
   } state_e;

   state_e      state_q;
   logic [7:0]  shreg_q;
   logic        sh_last_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  hold_q;
   logic        hold_last_q;
   logic        hold_full_q;
   logic        last_seen_q;
   logic        crc_rst_q;
   logic [31:0] frame_crc_q;
   logic        crc_valid_q;
   logic        underrun_q;
   logic        ready_d;
   logic        accept;

   always_comb begin
      ready_d = 1'b0;
      case (state_q)
         IDLE, DISCARD: ready_d = 1'b1;
         INIT, SHIFT:   ready_d = !hold_full_q && !last_seen_q;
         default:       ready_d = 1'b0;
      endcase
   end

   assign in_ready    = ready_d && !rst;
   assign accept      = in_valid && in_ready;
   assign bit_out     = shreg_q[7];
   assign crc_rst     = crc_rst_q;
   assign frame_crc   = frame_crc_q;
   assign crc_valid   = crc_valid_q;
   assign underrun    = underrun_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= 8'h00;
         sh_last_q   <= 1'b0;
         bit_cnt_q   <= 3'd0;
         hold_q      <= 8'h00;
         hold_last_q <= 1'b0;
         hold_full_q <= 1'b0;
         last_seen_q <= 1'b0;
         crc_rst_q   <= 1'b1;
         frame_crc_q <= 32'h0;
         crc_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         crc_rst_q   <= 1'b0;
         crc_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q     <= in_data;
                  sh_last_q   <= in_last;
                  last_seen_q <= in_last;
                  crc_rst_q   <= 1'b1;
                  state_q     <= INIT;
               end
            end
            INIT: begin
               bit_cnt_q <= 3'd0;
               state_q   <= SHIFT;
               if (accept) begin
                  hold_q      <= in_data;
                  hold_last_q <= in_last;
                  hold_full_q <= 1'b1;
                  last_seen_q <= in_last;
               end
            end
            SHIFT: begin
               shreg_q   <= {shreg_q[6:0], 1'b0};
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q != 3'd7) begin
                  if (accept) begin
                     hold_q      <= in_data;
                     hold_last_q <= in_last;
                     hold_full_q <= 1'b1;
                     last_seen_q <= in_last;
                  end
               end else if (sh_last_q) begin
                  state_q <= CAP1;
               end else if (hold_full_q) begin
                  shreg_q     <= hold_q;
                  sh_last_q   <= hold_last_q;
                  hold_full_q <= 1'b0;
               end else if (accept) begin
                  // Byte arriving exactly on the final bit of the current one: bypass hold.
                  shreg_q     <= in_data;
                  sh_last_q   <= in_last;
                  last_seen_q <= in_last;
               end else begin
                  underrun_q <= 1'b1;
                  if (last_seen_q) begin
                     last_seen_q <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     state_q <= DISCARD;
                  end
               end
            end
            CAP1: state_q <= CAP2;
            CAP2: begin
               frame_crc_q <= crc_in;
               crc_valid_q <= 1'b1;
               last_seen_q <= 1'b0;
               hold_full_q <= 1'b0;
               state_q     <= IDLE;
            end
            DISCARD: begin
               if (accept && in_last) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crc32_bit_feeder.sv
// Bench for crc32_bit_feeder: models the downstream CRC-32 stage, drives directed and
// random frames, and scores captured CRCs and underrun pulses against a bytewise model.
module tb_crc32_bit_feeder;

   typedef logic [7:0] bq_t[$];
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic        bit_out;
   logic        crc_rst;
   logic [31:0] crc_in;
   logic [31:0] frame_crc;
   logic        crc_valid;
   logic        underrun;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int vld_cnt  = 0;
   int vld_cyc  = -1;
   int urun_cnt = 0;
   int urun_cyc = -1;
   int exp_urun = 0;
   logic [31:0] exp_q[$];

   crc32_bit_feeder dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .bit_out(bit_out), .crc_rst(crc_rst), .crc_in(crc_in),
      .frame_crc(frame_crc), .crc_valid(crc_valid), .underrun(underrun),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream CRC stage: no enable, complemented registered output.
   logic [31:0] crc_reg;
   logic [31:0] crc_out_q;
   always @(posedge clk) begin
      if (crc_rst) crc_reg <= 32'hFFFF_FFFF;
      else         crc_reg <= {crc_reg[30:0], 1'b0} ^ ((crc_reg[31] ^ bit_out) ? POLY : 32'h0);
      crc_out_q <= ~crc_reg;
   end
   assign crc_in = crc_out_q;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_crc(input bq_t b);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c = c ^ {b[i], 24'h0};
         for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      end
      return ~c;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && crc_valid) begin
         vld_cnt++;
         vld_cyc = cyc;
         if (exp_q.size() == 0) check("crc_valid_unexpected", 32'd1, 32'd0);
         else check("frame_crc", frame_crc, exp_q.pop_front());
      end
      if (!rst && underrun) begin
         urun_cnt++;
         urun_cyc = cyc;
      end
   end

   // ---------------- driver tasks (entered/left #1 after a posedge) ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, output int acc);
      bit done = 1'b0;
      acc = -1;
      in_data = d; in_last = last; in_valid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin acc = cyc; done = 1'b1; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("accept_timeout", 32'd0, 32'd1);
   endtask

   // A frame survives iff byte k is accepted no later than cycle A+1+8k.
   task automatic send_frame(input bq_t b, input int gmax, output int acc0);
      int  acc[16];
      int  g;
      bit  good;
      for (int k = 0; k < b.size(); k++) begin
         g = 0;
         if (gmax > 0) begin
            if (k == 0) g = $urandom_range(0, 2);
            else if ($urandom_range(0, 3) == 0) g = $urandom_range(1, gmax);
         end
         if (g > 0) idle(g);
         send_byte(b[k], (k == b.size() - 1), acc[k]);
      end
      good = 1'b1;
      for (int k = 1; k < b.size(); k++)
         if (acc[k] > acc[0] + 1 + 8 * k) good = 1'b0;
      if (good) exp_q.push_back(ref_crc(b));
      else exp_urun++;
      acc0 = acc[0];
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bq_t s9, f, f2;
      int  a, a2, x, v0, u0;
      logic [7:0]  b0, b1;
      logic [15:0] bits;

      s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      idle(3);
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_crc_rst",   32'(crc_rst),   32'd1);
      check("rst_bit_out",   32'(bit_out),   32'd0);
      check("rst_frame_crc", frame_crc,      32'd0);
      check("rst_crc_valid", 32'(crc_valid), 32'd0);
      check("rst_underrun",  32'(underrun),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // "123456789" with in_valid held high
      vld_cyc = -1;
      send_frame(s9, 0, a);
      wait_until(a + 80);
      check("crc9_valid_cycle", 32'(vld_cyc), 32'(a + 76));
      check("crc9_value", frame_crc, 32'hFC891918);

      // Single byte 0xA5: bit order and timing
      vld_cyc = -1;
      send_byte(8'hA5, 1'b1, a);
      f = '{8'hA5};
      exp_q.push_back(ref_crc(f));
      @(negedge clk);
      check("a5_crc_rst", 32'(crc_rst), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("a5_bit", 32'(bit_out), 32'((8'hA5 >> (7 - i)) & 8'h01));
      end
      @(posedge clk); #1;
      wait_until(a + 14);
      check("a5_valid_cycle", 32'(vld_cyc), 32'(a + 12));
      @(negedge clk);
      check("idle_bit_out", 32'(bit_out), 32'd0);
      @(posedge clk); #1;

      // Bypass: byte 1 offered only in byte 0's final-bit cycle
      u0 = urun_cnt;
      b0 = 8'($urandom); b1 = 8'($urandom);
      send_byte(b0, 1'b0, a);
      @(negedge clk);
      check("bypass_crc_rst", 32'(crc_rst), 32'd1);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (i == 7) begin in_data = b1; in_last = 1'b1; in_valid = 1'b1; end
         if (i == 8) in_valid = 1'b0;
         @(negedge clk);
         bits[15 - i] = bit_out;
         if (i == 7) check("bypass_ready", 32'(in_ready), 32'd1);
      end
      @(posedge clk); #1;
      f = '{b0, b1};
      exp_q.push_back(ref_crc(f));
      check("bypass_stream", 32'(bits), 32'({b0, b1}));
      idle(10);
      check("bypass_no_underrun", 32'(urun_cnt), 32'(u0));

      // Underrun: byte 1 of a 3-byte frame withheld past the deadline
      u0 = urun_cnt; v0 = vld_cnt; urun_cyc = -1;
      send_byte(8'($urandom), 1'b0, a);
      idle(11);
      send_byte(8'($urandom), 1'b0, x);
      send_byte(8'($urandom), 1'b1, x);
      exp_urun++;
      idle(20);
      check("underrun_cycle", 32'(urun_cyc), 32'(a + 10));
      check("underrun_count", 32'(urun_cnt), 32'(u0 + 1));
      check("underrun_no_valid", 32'(vld_cnt), 32'(v0));
      f = '{8'($urandom), 8'($urandom), 8'($urandom)};
      send_frame(f, 0, a);
      idle(40);

      // Reset in the middle of SHIFT
      u0 = urun_cnt; v0 = vld_cnt;
      send_byte(8'h31, 1'b0, a);
      send_byte(8'h32, 1'b0, x);
      idle(2);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_crc_rst",   32'(crc_rst),   32'd1);
      check("midrst_bit_out",   32'(bit_out),   32'd0);
      check("midrst_frame_crc", frame_crc,      32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(20);
      check("midrst_no_underrun", 32'(urun_cnt), 32'(u0));
      check("midrst_no_valid",    32'(vld_cnt),  32'(v0));
      send_frame(s9, 0, a);
      wait_until(a + 80);
      check("midrst_crc9", frame_crc, 32'hFC891918);

      // Back-to-back frames, in_valid never dropped
      f.delete(); f2.delete();
      repeat ($urandom_range(1, 5)) f.push_back(8'($urandom));
      repeat ($urandom_range(1, 5)) f2.push_back(8'($urandom));
      send_frame(f, 0, a);
      send_frame(f2, 0, a2);
      check("b2b_second_accept", 32'(a2), 32'(a + 4 + 8 * f.size()));
      idle(60);

      // Random frames with random inter-byte gaps
      for (int n = 0; n < 30; n++) begin
         f.delete();
         repeat ($urandom_range(1, 6)) f.push_back(8'($urandom));
         send_frame(f, 12, a);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
      end
      idle(80);

      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      check("underrun_total", 32'(urun_cnt), 32'(exp_urun));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
